// File: rtl/adder_32u_stim_checker_if.sv
// Operand/result bus between the stimulus checker (master) and the adder
// wrapper under test (slave).
interface adder_32u_stim_checker_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;

    modport master (
        output a_out,
        output b_out,
        input  sum_in,
        input  cout_in
    );

    modport slave (
        input  a_out,
        input  b_out,
        output sum_in,
        output cout_in
    );
endinterface

// File: rtl/adder_32u_stim_checker.sv
// Self-checking traffic source for registered WIDTH-bit adder wrappers:
// drives corner and LFSR operands, predicts {cout,sum} and counts mismatches.
module adder_32u_stim_checker #(
    parameter int          WIDTH       = 32,
    parameter int          LATENCY     = 2,
    parameter int          NUM_VECTORS = 1024,
    parameter logic [31:0] SEED_A      = 32'h1,
    parameter logic [31:0] SEED_B      = 32'hACE1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    adder_32u_stim_checker_if.master      bus,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [15:0]                   err_count,
    output logic [15:0]                   first_err_idx
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
    localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;
    localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_DRAIN = 4'(LATENCY - 1);

    state_t           state_q;
    logic [WIDTH-1:0] aOut_q;
    logic [WIDTH-1:0] bOut_q;
    logic [31:0]      lfsrA_q;
    logic [31:0]      lfsrB_q;
    logic [15:0]      vecIdx_q;
    logic [3:0]       drainCnt_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      errCount_q;
    logic [15:0]      firstErrIdx_q;

    logic             pipeValid_q [LATENCY];
    logic [15:0]      pipeIdx_q   [LATENCY];
    logic [WIDTH:0]   pipeExp_q   [LATENCY];

    logic [15:0]      nextIdx;
    logic [WIDTH-1:0] vecA_d;
    logic [WIDTH-1:0] vecB_d;
    logic             useLfsr;
    logic             tailCheck;

    function automatic logic [31:0] lfsrStep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] altPattern(input logic oddSet);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int k = 0; k < WIDTH; k++) begin
            p[k] = ((k % 2) == 1) == oddSet;
        end
        return p;
    endfunction

    always_comb begin
        nextIdx = vecIdx_q + 16'd1;
        vecA_d  = WIDTH'(lfsrA_q);
        vecB_d  = WIDTH'(lfsrB_q);
        useLfsr = 1'b0;
        case (nextIdx)
            16'd1: begin
                vecA_d = '1;
                vecB_d = WIDTH'(1);
            end
            16'd2: begin
                vecA_d = '1;
                vecB_d = '1;
            end
            16'd3: begin
                vecA_d = altPattern(1'b1);
                vecB_d = altPattern(1'b0);
            end
            default: useLfsr = 1'b1;
        endcase
    end

    assign tailCheck = pipeValid_q[LATENCY-1] &&
                       ({bus.cout_in, bus.sum_in} != pipeExp_q[LATENCY-1]);

    // Control FSM; the tail compare sits above the case so a start in the
    // same cycle still wins when clearing the error statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            aOut_q        <= '0;
            bOut_q        <= '0;
            lfsrA_q       <= SEED_A_EFF;
            lfsrB_q       <= SEED_B_EFF;
            vecIdx_q      <= '0;
            drainCnt_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            errCount_q    <= '0;
            firstErrIdx_q <= 16'hFFFF;
        end else begin
            if (tailCheck) begin
                if (errCount_q != 16'hFFFF) begin
                    errCount_q <= errCount_q + 16'd1;
                end
                if (firstErrIdx_q == 16'hFFFF) begin
                    firstErrIdx_q <= pipeIdx_q[LATENCY-1];
                end
            end
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q       <= RUN;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        errCount_q    <= '0;
                        firstErrIdx_q <= 16'hFFFF;
                        vecIdx_q      <= '0;
                        aOut_q        <= '0;
                        bOut_q        <= '0;
                        lfsrA_q       <= SEED_A_EFF;
                        lfsrB_q       <= SEED_B_EFF;
                    end
                end
                RUN: begin
                    if (vecIdx_q == LAST_VEC) begin
                        state_q    <= DRAIN;
                        aOut_q     <= '0;
                        bOut_q     <= '0;
                        drainCnt_q <= '0;
                    end else begin
                        vecIdx_q <= nextIdx;
                        aOut_q   <= vecA_d;
                        bOut_q   <= vecB_d;
                        if (useLfsr) begin
                            lfsrA_q <= lfsrStep(lfsrA_q);
                            lfsrB_q <= lfsrStep(lfsrB_q);
                        end
                    end
                end
                DRAIN: begin
                    if (drainCnt_q == LAST_DRAIN) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drainCnt_q <= drainCnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Expectation pipe: entry i is written while vector i is on the bus and
    // reaches the tail exactly LATENCY cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                pipeValid_q[s] <= 1'b0;
                pipeIdx_q[s]   <= '0;
                pipeExp_q[s]   <= '0;
            end
        end else begin
            pipeValid_q[0] <= (state_q == RUN);
            pipeIdx_q[0]   <= vecIdx_q;
            pipeExp_q[0]   <= {1'b0, aOut_q} + {1'b0, bOut_q};
            for (int s = 1; s < LATENCY; s++) begin
                pipeValid_q[s] <= pipeValid_q[s-1];
                pipeIdx_q[s]   <= pipeIdx_q[s-1];
                pipeExp_q[s]   <= pipeExp_q[s-1];
            end
        end
    end

    assign bus.a_out     = aOut_q;
    assign bus.b_out     = bOut_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = done_q && (errCount_q == 16'd0);
    assign err_count     = errCount_q;
    assign first_err_idx = firstErrIdx_q;

endmodule

// File: tb/tb_adder_32u_stim_checker.sv
// Bench for adder_32u_stim_checker: five checkers run against ideal, faulty,
// late, randomly corrupted and inverted adder models.
module tb_adder_32u_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstMain, rstAll;
    logic startMain, startStuck, startLat, startRand, startSat;

    adder_32u_stim_checker_if #(.WIDTH(32)) busMain ();
    adder_32u_stim_checker_if #(.WIDTH(32)) busStuck ();
    adder_32u_stim_checker_if #(.WIDTH(32)) busLat ();
    adder_32u_stim_checker_if #(.WIDTH(32)) busRand ();
    adder_32u_stim_checker_if #(.WIDTH(32)) busSat ();

    logic        busyMain, doneMain, passMain;
    logic [15:0] errMain, firstMain;
    logic        busyStuck, doneStuck, passStuck;
    logic [15:0] errStuck, firstStuck;
    logic        busyLat, doneLat, passLat;
    logic [15:0] errLat, firstLat;
    logic        busyRand, doneRand, passRand;
    logic [15:0] errRand, firstRand;
    logic        busySat, doneSat, passSat;
    logic [15:0] errSat, firstSat;

    adder_32u_stim_checker #(.NUM_VECTORS(16)) dutMain (
        .clk(clk), .rst(rstMain), .start(startMain), .bus(busMain),
        .busy(busyMain), .done(doneMain), .pass(passMain),
        .err_count(errMain), .first_err_idx(firstMain));

    adder_32u_stim_checker #(.NUM_VECTORS(4)) dutStuck (
        .clk(clk), .rst(rstAll), .start(startStuck), .bus(busStuck),
        .busy(busyStuck), .done(doneStuck), .pass(passStuck),
        .err_count(errStuck), .first_err_idx(firstStuck));

    adder_32u_stim_checker #(.NUM_VECTORS(16)) dutLat (
        .clk(clk), .rst(rstAll), .start(startLat), .bus(busLat),
        .busy(busyLat), .done(doneLat), .pass(passLat),
        .err_count(errLat), .first_err_idx(firstLat));

    adder_32u_stim_checker #(.NUM_VECTORS(64)) dutRand (
        .clk(clk), .rst(rstAll), .start(startRand), .bus(busRand),
        .busy(busyRand), .done(doneRand), .pass(passRand),
        .err_count(errRand), .first_err_idx(firstRand));

    adder_32u_stim_checker #(.NUM_VECTORS(65535)) dutSat (
        .clk(clk), .rst(rstAll), .start(startSat), .bus(busSat),
        .busy(busySat), .done(doneSat), .pass(passSat),
        .err_count(errSat), .first_err_idx(firstSat));

    // Adder models standing in for the wrapper under test.
    logic [32:0] mainS1, mainS2, stuckS1, stuckS2, latS1, latS2, latS3;
    logic [32:0] randS1, randS2, satS1, satS2;
    logic [32:0] randMask [64];
    int          randCnt;

    always_ff @(posedge clk) begin
        mainS1  <= 33'(busMain.a_out) + 33'(busMain.b_out);
        mainS2  <= mainS1;
        stuckS1 <= 33'(busStuck.a_out) + 33'(busStuck.b_out);
        stuckS2 <= stuckS1;
        latS1   <= 33'(busLat.a_out) + 33'(busLat.b_out);
        latS2   <= latS1;
        latS3   <= latS2;
        randS1  <= (33'(busRand.a_out) + 33'(busRand.b_out)) ^
                   ((randCnt < 64) ? randMask[randCnt] : 33'd0);
        randS2  <= randS1;
        satS1   <= 33'(busSat.a_out) + 33'(busSat.b_out);
        satS2   <= satS1;
        if (rstAll) randCnt <= 64;
        else if (startRand && !busyRand) randCnt <= 0;
        else if (randCnt < 64) randCnt <= randCnt + 1;
    end

    assign {busMain.cout_in, busMain.sum_in}   = mainS2;
    assign {busStuck.cout_in, busStuck.sum_in} = {stuckS2[32:1], 1'b0};
    assign {busLat.cout_in, busLat.sum_in}     = latS3;
    assign {busRand.cout_in, busRand.sum_in}   = randS2;
    assign busSat.cout_in = satS2[32];
    assign busSat.sum_in  = ~satS2[31:0];

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] refA [64];
    logic [31:0] refB [64];

    function automatic logic [31:0] lfsrNext(input logic [31:0] s);
        if (s % 2 == 1) return (s >> 1) ^ 32'h80200003;
        return s >> 1;
    endfunction

    task automatic applyStimulus(input logic [4:0] starts, input logic rstM);
        @(negedge clk);
        {startSat, startRand, startLat, startStuck, startMain} = starts;
        rstMain = rstM;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    initial begin
        logic [31:0] lfA, lfB;
        logic [32:0] cur, prev;
        logic [15:0] expErr, expFirst;
        logic        sawBusy, seenDone;

        lfA = 32'h1;
        lfB = 32'hACE1;
        for (int i = 0; i < 64; i++) begin
            case (i)
                0: begin refA[i] = 32'h0;        refB[i] = 32'h0;        end
                1: begin refA[i] = 32'hFFFFFFFF; refB[i] = 32'h1;        end
                2: begin refA[i] = 32'hFFFFFFFF; refB[i] = 32'hFFFFFFFF; end
                3: begin refA[i] = 32'hAAAAAAAA; refB[i] = 32'h55555555; end
                default: begin
                    refA[i] = lfA;
                    refB[i] = lfB;
                    lfA = lfsrNext(lfA);
                    lfB = lfsrNext(lfB);
                end
            endcase
            randMask[i] = ($urandom_range(0, 2) == 0) ? {1'($urandom_range(0, 1)), $urandom} : 33'd0;
        end

        rstMain = 1'b1;
        rstAll  = 1'b1;
        {startSat, startRand, startLat, startStuck, startMain} = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 64'(busyMain), 64'd0);
        checkOutput("rst_done", 64'(doneMain), 64'd0);
        checkOutput("rst_pass", 64'(passMain), 64'd0);
        checkOutput("rst_err", 64'(errMain), 64'd0);
        checkOutput("rst_first", 64'(firstMain), 64'hFFFF);
        checkOutput("rst_ab", {busMain.a_out, busMain.b_out}, 64'd0);
        rstAll = 1'b0;
        applyStimulus(5'b00000, 1'b0);

        // Clean run on the ideal model; every DUT starts together here.
        applyStimulus(5'b11111, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            applyStimulus(5'b00000, 1'b0);
            if (k <= 16)
                checkOutput($sformatf("run1_vec%0d", k - 1), {busMain.a_out, busMain.b_out},
                            {refA[k-1], refB[k-1]});
            else
                checkOutput($sformatf("run1_idle_ab%0d", k), {busMain.a_out, busMain.b_out}, 64'd0);
            checkOutput($sformatf("run1_busy%0d", k), 64'(busyMain), 64'(k <= 18));
            checkOutput($sformatf("run1_done%0d", k), 64'(doneMain), 64'(k == 19));
        end
        checkOutput("run1_pass", 64'(passMain), 64'd1);
        checkOutput("run1_err", 64'(errMain), 64'd0);
        checkOutput("run1_first", 64'(firstMain), 64'hFFFF);
        checkOutput("stuck_done", 64'(doneStuck), 64'd1);
        checkOutput("stuck_err", 64'(errStuck), 64'd1);
        checkOutput("stuck_first", 64'(firstStuck), 64'd3);
        checkOutput("stuck_pass", 64'(passStuck), 64'd0);

        // Restart main from DONE with stray start pulses in RUN and DRAIN;
        // restart the stuck checker to see err_count cleared on RUN entry.
        applyStimulus(5'b00011, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            applyStimulus((k == 6 || k == 17) ? 5'b00001 : 5'b00000, 1'b0);
            if (k == 1) begin
                checkOutput("restart_stuck_busy", 64'(busyStuck), 64'd1);
                checkOutput("restart_stuck_err", 64'(errStuck), 64'd0);
                checkOutput("restart_stuck_done", 64'(doneStuck), 64'd0);
                checkOutput("restart_stuck_first", 64'(firstStuck), 64'hFFFF);
            end
            checkOutput($sformatf("run2_done%0d", k), 64'(doneMain), 64'(k == 19));
            checkOutput($sformatf("run2_busy%0d", k), 64'(busyMain), 64'(k <= 18));
        end
        checkOutput("run2_pass", 64'(passMain), 64'd1);
        checkOutput("restart_stuck_err_final", 64'(errStuck), 64'd1);

        // Reset in RUN cycle 7 aborts the run.
        applyStimulus(5'b00001, 1'b0);
        for (int k = 1; k <= 8; k++) applyStimulus(5'b00000, k == 8);
        applyStimulus(5'b00000, 1'b0);
        checkOutput("abort_busy", 64'(busyMain), 64'd0);
        checkOutput("abort_done", 64'(doneMain), 64'd0);
        checkOutput("abort_pass", 64'(passMain), 64'd0);
        checkOutput("abort_err", 64'(errMain), 64'd0);
        checkOutput("abort_first", 64'(firstMain), 64'hFFFF);
        checkOutput("abort_ab", {busMain.a_out, busMain.b_out}, 64'd0);
        sawBusy = 1'b0;
        seenDone = 1'b0;
        repeat (25) begin
            applyStimulus(5'b00000, 1'b0);
            sawBusy  |= busyMain;
            seenDone |= doneMain;
        end
        checkOutput("abort_no_done", 64'(seenDone), 64'd0);
        checkOutput("abort_stays_idle", 64'(sawBusy), 64'd0);

        // Fresh run after the abort repeats the same sequence.
        applyStimulus(5'b00001, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            applyStimulus(5'b00000, 1'b0);
            if (k == 5)
                checkOutput("rerun_vec4", {busMain.a_out, busMain.b_out}, {refA[4], refB[4]});
            if (k == 19) checkOutput("rerun_done", 64'(doneMain), 64'd1);
        end
        checkOutput("rerun_pass", 64'(passMain), 64'd1);

        // Model with one extra cycle of latency: vector i sees vector i-1.
        expErr = 0;
        expFirst = 16'hFFFF;
        prev = 33'd0;
        for (int i = 0; i < 16; i++) begin
            cur = 33'(refA[i]) + 33'(refB[i]);
            if (cur != prev) begin
                expErr++;
                if (expFirst == 16'hFFFF) expFirst = 16'(i);
            end
            prev = cur;
        end
        checkOutput("lat_done", 64'(doneLat), 64'd1);
        checkOutput("lat_err", 64'(errLat), 64'(expErr));
        checkOutput("lat_first", 64'(firstLat), 64'd1);
        checkOutput("lat_pass", 64'(passLat), 64'd0);

        // Randomly corrupted results.
        expErr = 0;
        expFirst = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            if (randMask[i] != 33'd0) begin
                expErr++;
                if (expFirst == 16'hFFFF) expFirst = 16'(i);
            end
        end
        checkOutput("rand_done", 64'(doneRand), 64'd1);
        checkOutput("rand_err", 64'(errRand), 64'(expErr));
        checkOutput("rand_first", 64'(firstRand), 64'(expFirst));
        checkOutput("rand_pass", 64'(passRand), 64'(expErr == 0));

        // Inverted sums on every one of 65535 vectors saturate the count.
        seenDone = 1'b0;
        for (int c = 0; c < 70000 && !seenDone; c++) begin
            applyStimulus(5'b00000, 1'b0);
            seenDone = doneSat;
        end
        checkOutput("sat_done_in_budget", 64'(seenDone), 64'd1);
        checkOutput("sat_err", 64'(errSat), 64'hFFFF);
        checkOutput("sat_first", 64'(firstSat), 64'd0);
        checkOutput("sat_pass", 64'(passSat), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
